key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/key_pkg.sv | 18 +
 rtl/key_lfsr16.sv | 14 +
 rtl/key_expansion.sv | 93 +++++++++
 tb/tb_key_expansion.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and FSM state type for the seed-to-key expansion block.
package key_pkg;

  localparam int KEY_W  = 512;
  localparam int SEED_W = 16;
  localparam int NWORDS = KEY_W / SEED_W;

  // Feedback taps at bits 15, 13, 12 and 10 of the 16-bit LFSR.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] SEED_SUBST = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_HOLD   = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_lfsr16.sv
// One step of the 16-bit Fibonacci LFSR used to expand the seed; purely combinational.
module key_lfsr16
  import key_pkg::*;
(
  input  logic [15:0] i_s,
  output logic [15:0] o_s_next
);

  logic w_feedback;

  assign w_feedback = ^(i_s & LFSR_TAPS);
  assign o_s_next   = {i_s[14:0], w_feedback};

endmodule

// File: rtl/key_expansion.sv
// Expands a 16-bit seed into a KEY_W-bit key, one LFSR word per cycle,
// then holds the result until the consumer takes it.
module key_expansion
  import key_pkg::*;
#(
  parameter int KEY_W  = key_pkg::KEY_W,
  parameter int SEED_W = key_pkg::SEED_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEED_W-1:0] seed,
  output logic              busy,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [KEY_W-1:0]  key,
  output logic [1:0]        o_dbg_state
);

  localparam int                CNT_W    = $clog2(KEY_W / SEED_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(KEY_W / SEED_W - 1);

  // Handshake: key_valid rises only with a complete key and stays high, with key
  // frozen, until a cycle where key_ready is also high; that edge retires the key.
  key_state_e        r_state;
  key_state_e        w_state_next;
  logic [SEED_W-1:0] r_s;
  logic [CNT_W-1:0]  r_cnt;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_valid;
  logic [SEED_W-1:0] w_s_next;
  logic [SEED_W-1:0] w_word;

  key_lfsr16 u_lfsr (
    .i_s      (r_s),
    .o_s_next (w_s_next)
  );

  assign w_word = w_s_next ^ {{(SEED_W - CNT_W){1'b0}}, r_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start)             w_state_next = ST_EXPAND;
      ST_EXPAND: if (r_cnt == CNT_LAST) w_state_next = ST_HOLD;
      ST_HOLD:   if (key_ready)         w_state_next = ST_IDLE;
      default:                          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR at zero.
            r_s   <= (seed == '0) ? SEED_SUBST : seed;
            r_cnt <= '0;
          end
        end
        ST_EXPAND: begin
          r_s   <= w_s_next;
          r_key <= {r_key[KEY_W-SEED_W-1:0], w_word};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_key_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (key_ready) r_key_valid <= 1'b0;
        end
        default: r_key_valid <= 1'b0;
      endcase
    end
  end

  assign busy        = (r_state == ST_EXPAND);
  assign key_valid   = r_key_valid;
  assign key         = r_key;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: stimulus pushes golden keys, a monitor pops on handshake.
module tb_key_expansion;

  localparam int KW = 512;
  localparam int SW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] seed;
  logic          busy;
  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key;
  logic [1:0]    dbg_state;

  logic [KW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            overlap_cnt = 0;

  key_expansion #(.KEY_W(KW), .SEED_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .seed        (seed),
    .busy        (busy),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key         (key),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [KW-1:0] golden(input logic [SW-1:0] sd);
    logic [15:0]   s;
    logic [KW-1:0] k;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    k = '0;
    for (int i = 0; i < KW / SW; i++) begin
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      k = {k[KW-SW-1:0], s ^ 16'(i)};
    end
    return k;
  endfunction

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic issue(input logic [SW-1:0] sd);
    int n;
    n = 0;
    while (dbg_state != 2'd0 && n < 200) begin
      step();
      n++;
    end
    check("issue_wait_idle", KW'(dbg_state), KW'(0));
    start = 1'b1;
    seed  = sd;
    exp_q.push_back(golden(sd));
    step();
    start = 1'b0;
    seed  = $urandom_range(0, 65535);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!key_valid && edges < 100) begin
      step();
      edges++;
    end
    check("wait_valid_timeout", KW'(key_valid), KW'(1));
  endtask

  task automatic consume(input int delay);
    int e;
    wait_valid(e);
    for (int i = 0; i < delay; i++) step();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  // scoreboard monitor: compares on every handshake
  always @(negedge clk) begin
    if (busy && key_valid) overlap_cnt++;
    if (rst_n && key_valid && key_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_key: got %0h want none", key);
      end else begin
        logic [KW-1:0] e;
        e = exp_q.pop_front();
        if (key !== e) begin
          n_fail++;
          $display("FAIL sb_key: got %0h want %0h", key, e);
        end
      end
    end
  end

  initial begin
    int            lat;
    int            vcnt;
    logic [KW-1:0] g;
    logic [15:0]   w0;
    logic [15:0]   w1;

    rst_n     = 1'b0;
    start     = 1'b0;
    seed      = '0;
    key_ready = 1'b0;
    step();
    step();
    check("rst_busy", KW'(busy), KW'(0));
    check("rst_valid", KW'(key_valid), KW'(0));
    check("rst_key", key, '0);
    check("rst_state", KW'(dbg_state), KW'(0));
    rst_n = 1'b1;
    step();

    // seed 1: first two words and exact latency
    issue(16'h0001);
    wait_valid(lat);
    check("latency_32", KW'(lat), KW'(32));
    w0 = key[511:496];
    w1 = key[495:480];
    check("seed1_word0", KW'(w0), KW'(16'h0002));
    check("seed1_word1", KW'(w1), KW'(16'h0005));
    consume(0);

    // zero seed substitution
    issue(16'h0000);
    wait_valid(lat);
    w0 = key[511:496];
    check("seed0_word0", KW'(w0), KW'(16'h59C3));
    consume(0);

    // back-pressure in HOLD
    issue(16'h1234);
    g = golden(16'h1234);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) step();
    check("hold_valid", KW'(key_valid), KW'(1));
    check("hold_key", key, g);
    check("hold_busy", KW'(busy), KW'(0));
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("hs_valid_low", KW'(key_valid), KW'(0));
    check("hs_state_idle", KW'(dbg_state), KW'(0));
    check("hs_key_retained", key, g);

    // start ignored in EXPAND and in HOLD alongside key_ready
    issue(16'hBEEF);
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    seed  = 16'h4321;
    step();
    start = 1'b0;
    wait_valid(lat);
    start     = 1'b1;
    seed      = 16'h7777;
    key_ready = 1'b1;
    step();
    start     = 1'b0;
    key_ready = 1'b0;
    check("ign_state_idle", KW'(dbg_state), KW'(0));
    check("ign_busy", KW'(busy), KW'(0));
    check("ign_key", key, golden(16'hBEEF));

    // reset mid-EXPAND at cnt=10
    issue(16'h00F0);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", KW'(busy), KW'(0));
    check("abort_key", key, '0);
    check("abort_valid", KW'(key_valid), KW'(0));
    exp_q.delete();
    step();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (key_valid || busy) vcnt++;
    end
    check("abort_stays_idle", KW'(vcnt), KW'(0));

    // random back-to-back traffic
    for (int i = 0; i < 100; i++) begin
      issue(16'($urandom_range(0, 65535)));
      consume($urandom_range(0, 5));
    end

    for (int i = 0; i < 3; i++) step();
    check("queue_drained", KW'(exp_q.size()), KW'(0));
    check("no_busy_valid_overlap", KW'(overlap_cnt), KW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
